// File: rtl/jstep_monitor.sv
`default_nettype none
// ============================================================================
// Module   : jstep_monitor
// Purpose  : Decodes the one-hot stepper bus into a step index, counts
//            completed 6-step instruction cycles and raises sticky protocol
//            error flags (non-one-hot, out-of-order, stall).
// Revision : 1.0 - initial release
// ============================================================================
module jstep_monitor #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wclk,
    input  logic [0:5]    bos,
    input  logic          clear_err,
    output logic [2:0]    step_idx,
    output logic          step_valid,
    output logic          cycle_done,
    output logic [CW-1:0] instr_count,
    output logic          err_onehot,
    output logic          err_order,
    output logic          err_stall,
    output logic          err_any
);

    localparam logic [8:0] c_timeout = 9'(TIMEOUT);

    typedef enum logic [0:0] {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_wclk_q;
    logic [2:0]      r_step_idx;
    logic [2:0]      r_expected;
    logic            r_step_valid;
    logic            r_cycle_done;
    logic [CW-1:0]   r_instr_count;
    logic [7:0]      r_stall_cnt;
    logic            r_err_onehot;
    logic            r_err_order;
    logic            r_err_stall;
    logic            r_err_any;

    logic            w_event;
    logic            w_onehot;
    logic [2:0]      w_idx;
    logic [2:0]      w_bits;
    logic            w_run;
    logic            w_stall_hit;
    logic            w_nxt_onehot;
    logic            w_nxt_order;
    logic            w_nxt_stall;

    // Event is the mid-step falling edge of wclk, seen through one sample register.
    always_comb begin
        w_idx  = 3'd0;
        w_bits = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (bos[i]) begin
                w_idx  = 3'(i);
                w_bits = w_bits + 3'd1;
            end
        end
        w_onehot    = (w_bits == 3'd1);
        w_event     = r_wclk_q & ~wclk;
        w_run       = (r_state == S_RUN);
        w_stall_hit = w_run & ~w_event & (({1'b0, r_stall_cnt} + 9'd1) >= c_timeout);
    end

    // A newly detected error overrides a simultaneous clear.
    always_comb begin
        w_nxt_onehot = (r_err_onehot & ~clear_err) | (w_run & w_event & ~w_onehot);
        w_nxt_order  = (r_err_order  & ~clear_err) |
                       (w_run & w_event & w_onehot & (w_idx != r_expected));
        w_nxt_stall  = (r_err_stall  & ~clear_err) | w_stall_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_SYNC;
            r_wclk_q      <= 1'b0;
            r_step_idx    <= 3'd0;
            r_expected    <= 3'd0;
            r_step_valid  <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_instr_count <= '0;
            r_stall_cnt   <= 8'd0;
            r_err_onehot  <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_stall   <= 1'b0;
            r_err_any     <= 1'b0;
        end else begin
            r_wclk_q     <= wclk;
            r_cycle_done <= 1'b0;
            r_err_onehot <= w_nxt_onehot;
            r_err_order  <= w_nxt_order;
            r_err_stall  <= w_nxt_stall;
            r_err_any    <= w_nxt_onehot | w_nxt_order | w_nxt_stall;

            case (r_state)
                S_SYNC: begin
                    r_stall_cnt <= 8'd0;
                    if (w_event && w_onehot && (w_idx == 3'd0)) begin
                        r_state      <= S_RUN;
                        r_step_valid <= 1'b1;
                        r_step_idx   <= 3'd0;
                        r_expected   <= 3'd1;
                    end
                end
                S_RUN: begin
                    if (w_event) begin
                        r_stall_cnt <= 8'd0;
                        if (w_onehot) begin
                            // Out-of-order steps resynchronise to the observed index.
                            r_step_idx <= w_idx;
                            r_expected <= (w_idx == 3'd5) ? 3'd0 : w_idx + 3'd1;
                            if (w_idx == 3'd5) begin
                                r_cycle_done  <= 1'b1;
                                r_instr_count <= r_instr_count + CW'(1);
                            end
                        end else begin
                            r_state      <= S_SYNC;
                            r_step_valid <= 1'b0;
                        end
                    end else if (w_stall_hit) begin
                        r_state      <= S_SYNC;
                        r_step_valid <= 1'b0;
                        r_stall_cnt  <= 8'd0;
                    end else if (r_stall_cnt != 8'hFF) begin
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state      <= S_SYNC;
                    r_step_valid <= 1'b0;
                end
            endcase
        end
    end

    assign step_idx    = r_step_idx;
    assign step_valid  = r_step_valid;
    assign cycle_done  = r_cycle_done;
    assign instr_count = r_instr_count;
    assign err_onehot  = r_err_onehot;
    assign err_order   = r_err_order;
    assign err_stall   = r_err_stall;
    assign err_any     = r_err_any;

endmodule
`default_nettype wire

// File: tb/tb_jstep_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_jstep_monitor
// Purpose  : Table-driven self-checking bench for jstep_monitor (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jstep_monitor;

    logic        clk;
    logic        reset;
    logic        wclk;
    logic [0:5]  bos;
    logic        clear_err;
    logic [2:0]  step_idx;
    logic        step_valid;
    logic        cycle_done;
    logic [15:0] instr_count;
    logic        err_onehot;
    logic        err_order;
    logic        err_stall;
    logic        err_any;

    jstep_monitor #(.TIMEOUT(8), .CW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .wclk        (wclk),
        .bos         (bos),
        .clear_err   (clear_err),
        .step_idx    (step_idx),
        .step_valid  (step_valid),
        .cycle_done  (cycle_done),
        .instr_count (instr_count),
        .err_onehot  (err_onehot),
        .err_order   (err_order),
        .err_stall   (err_stall),
        .err_any     (err_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic        v;
        logic        cd;
        logic [15:0] cnt;
        logic        eo;
        logic        er;
        logic        es;
    } exp_t;

    typedef struct {
        string      nm;
        logic       wclk;
        logic [0:5] bos;
        logic       clr;
        exp_t       e;
    } vec_t;

    vec_t  vecs[$];
    exp_t  cur;
    string phase;
    int    checks;
    int    failures;

    function automatic logic [0:5] oh(input int k);
        logic [0:5] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk(input logic [2:0] idx, input logic v, input logic cd,
                                input int cnt, input logic eo, input logic er, input logic es);
        exp_t e;
        e.idx = idx; e.v = v; e.cd = cd; e.cnt = cnt[15:0];
        e.eo = eo; e.er = er; e.es = es;
        return e;
    endfunction

    // One clock record; cur tracks the expected outputs after it.
    task automatic hold(input logic w, input logic [0:5] b, input logic clr, input exp_t e);
        vec_t r;
        r.nm = $sformatf("%s#%0d", phase, vecs.size());
        r.wclk = w; r.bos = b; r.clr = clr; r.e = e;
        vecs.push_back(r);
        cur = e;
    endtask

    // A full step: wclk high (no event), then wclk low (event at that edge).
    task automatic ev(input logic [0:5] b, input logic clr, input exp_t e);
        exp_t a;
        a    = cur;
        a.cd = 1'b0;
        hold(1'b1, b, 1'b0, a);
        hold(1'b0, b, clr, e);
    endtask

    task automatic check(input string nm, input exp_t e);
        logic [24:0] act;
        logic [24:0] req;
        act = {step_idx, step_valid, cycle_done, instr_count,
               err_onehot, err_order, err_stall, err_any};
        req = {e.idx, e.v, e.cd, e.cnt, e.eo, e.er, e.es, (e.eo | e.er | e.es)};
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual{idx,v,cd,cnt,eo,er,es,any}=%h required=%h", nm, act, req);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            wclk      = vecs[i].wclk;
            bos       = vecs[i].bos;
            clear_err = vecs[i].clr;
            @(posedge clk);
            #1;
            check(vecs[i].nm, vecs[i].e);
        end
        vecs.delete();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        wclk      = 1'b0;
        bos       = '0;
        clear_err = 1'b0;
        cur       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b1;

        phase = "sync_ignore";
        ev(oh(3),    1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        ev(6'b000000, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));

        phase = "nominal";
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < 6; s++)
                ev(oh(s), 1'b0, mk(3'(s), 1, (s == 5), c + ((s == 5) ? 1 : 0), 0, 0, 0));

        phase = "order";
        ev(oh(0),     1'b0, mk(0, 1, 0, 3, 0, 0, 0));
        ev(oh(1),     1'b0, mk(1, 1, 0, 3, 0, 0, 0));
        ev(6'b000010, 1'b0, mk(4, 1, 0, 3, 0, 1, 0));
        ev(oh(5),     1'b0, mk(5, 1, 1, 4, 0, 1, 0));

        phase = "clear_prio";
        ev(oh(2), 1'b1, mk(2, 1, 0, 4, 0, 1, 0));
        hold(1'b0, '0, 1'b1, mk(2, 1, 0, 4, 0, 0, 0));

        phase = "onehot";
        ev(6'b000000, 1'b0, mk(2, 0, 0, 4, 1, 0, 0));
        ev(oh(0),     1'b0, mk(0, 1, 0, 4, 1, 0, 0));
        hold(1'b0, '0, 1'b1, mk(0, 1, 0, 4, 0, 0, 0));
        ev(6'b110000, 1'b0, mk(0, 0, 0, 4, 1, 0, 0));
        ev(6'b110000, 1'b0, mk(0, 0, 0, 4, 1, 0, 0));
        hold(1'b0, '0, 1'b1, mk(0, 0, 0, 4, 0, 0, 0));
        ev(oh(0),     1'b0, mk(0, 1, 0, 4, 0, 0, 0));

        phase = "stall";
        for (int i = 0; i < 7; i++) hold(1'b0, '0, 1'b0, mk(0, 1, 0, 4, 0, 0, 0));
        hold(1'b0, '0, 1'b0, mk(0, 0, 0, 4, 0, 0, 1));
        hold(1'b0, '0, 1'b1, mk(0, 0, 0, 4, 0, 0, 0));

        phase = "no_stall_e7";
        ev(oh(0), 1'b0, mk(0, 1, 0, 4, 0, 0, 0));
        for (int i = 0; i < 5; i++) hold(1'b0, '0, 1'b0, mk(0, 1, 0, 4, 0, 0, 0));
        hold(1'b1, oh(1), 1'b0, mk(0, 1, 0, 4, 0, 0, 0));
        hold(1'b0, oh(1), 1'b0, mk(1, 1, 0, 4, 0, 0, 0));
        hold(1'b0, oh(1), 1'b0, mk(1, 1, 0, 4, 0, 0, 0));

        phase = "e_wins_e8";
        for (int i = 0; i < 5; i++) hold(1'b0, oh(1), 1'b0, mk(1, 1, 0, 4, 0, 0, 0));
        hold(1'b1, oh(2), 1'b0, mk(1, 1, 0, 4, 0, 0, 0));
        hold(1'b0, oh(2), 1'b0, mk(2, 1, 0, 4, 0, 0, 0));
        hold(1'b0, oh(2), 1'b0, mk(2, 1, 0, 4, 0, 0, 0));

        phase = "to_five";
        ev(oh(3), 1'b0, mk(3, 1, 0, 4, 0, 0, 0));
        ev(oh(4), 1'b0, mk(4, 1, 0, 4, 0, 0, 0));
        ev(oh(5), 1'b0, mk(5, 1, 1, 5, 0, 0, 0));
        ev(oh(0), 1'b0, mk(0, 1, 0, 5, 0, 0, 0));
        ev(oh(1), 1'b0, mk(1, 1, 0, 5, 0, 0, 0));
        hold(1'b1, oh(2), 1'b0, mk(1, 1, 0, 5, 0, 0, 0));
        run_vecs();

        // Asynchronous reset in the middle of step 3, checked before the next edge.
        check("pre_reset", mk(1, 1, 0, 5, 0, 0, 0));
        #2 reset = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b1;

        cur   = '0;
        phase = "after_reset";
        ev(oh(2), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        ev(oh(0), 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
        ev(oh(1), 1'b0, mk(1, 1, 0, 0, 0, 0, 0));
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
